// File: rtl/seg7_scan_pkg.sv
// Shared constants for the multiplexed seven-segment driver: off patterns,
// hex glyph table and the slot-counter width helper.
package seg7_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry F first so GLYPH_TABLE[n] is nibble n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int tick_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
  import seg7_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver with frame snapshot, anode guard
// interval, leading-zero blanking and per-digit decimal points.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE*4-1:0] value,
  input  logic [SIZE-1:0]   dp_in,
  input  logic              lz_en,
  input  logic              blank,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int             TW         = tick_w(DIV);
  localparam logic [TW-1:0]  TICK_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0]  TICK_GUARD = TW'(GUARD);
  localparam logic [1:0]     IDX_LAST   = 2'(SIZE - 1);

  logic [TW-1:0]     r_tick;
  logic [1:0]        r_idx;
  logic [SIZE*4-1:0] r_val_s;
  logic [SIZE-1:0]   r_dp_s;
  logic              r_lz_s;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic              w_tick_last;
  logic              w_frame_end;
  logic [15:0]       w_val_pad;
  logic [3:0]        w_dp_pad;
  logic [3:0]        w_upper_zero;
  logic [3:0]        w_nib;
  logic [6:0]        w_glyph;
  logic              w_lz_blank;
  logic              w_dark;

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_frame_end = w_tick_last && (r_idx == IDX_LAST);

  // Missing upper digits read as zero, which is what blanking wants anyway.
  assign w_val_pad = 16'(r_val_s);
  assign w_dp_pad  = 4'(r_dp_s);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_upper_zero
      assign w_upper_zero[gi] = ~|w_val_pad[15:gi*4];
    end
  endgenerate

  assign w_nib      = w_val_pad[{r_idx, 2'b00} +: 4];
  assign w_lz_blank = r_lz_s && (r_idx != 2'd0) && w_upper_zero[r_idx];
  assign w_dark     = blank || (r_tick < TICK_GUARD);

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_tick_last) begin
      r_tick <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  // Inputs are only sampled at frame end so a frame never mixes two values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val_s <= '0;
      r_dp_s  <= '0;
      r_lz_s  <= 1'b0;
    end else if (w_frame_end) begin
      r_val_s <= value;
      r_dp_s  <= dp_in;
      r_lz_s  <= lz_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (w_dark) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_lz_blank ? SEG_OFF : w_glyph;
      r_dp  <= ~w_dp_pad[r_idx];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed four-digit, seven-segment hex display driver for the BASYS2 board.
- Consumes the packed hex-nibble count bus produced by the push-button counter (SIZE nibbles, digit 0 in bits [3:0]).
- Time-multiplexes the nibbles onto the shared active-low cathodes and anodes.
- Adds a frame-synchronous snapshot (no tearing), a ghosting guard interval, leading-zero blanking and per-digit decimal points.

Parameters:
- SIZE, 4: number of digits displayed, legal 1..4.
- DIV, 50000: clk cycles per digit slot, ≥ GUARD+2.
- GUARD, 500: cycles at the start of each slot with all anodes off, ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- value  input  SIZE*4  packed hex digits; nibble i = digit i.
- dp_in  input  SIZE  decimal-point enable per digit, 1 = lit.
- lz_en  input  1  leading-zero blanking enable.
- blank  input  1  force display dark.
- an  output  4  anodes, active-low; an[i] = digit i.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal-point cathode, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - an=4'hF, seg=7'h7F, dp=1.
  - Slot counter tick=0, digit index idx=0.
  - Snapshot registers val_s=0, dp_s=0, lz_s=0.
  - All outputs are held while rst=0. The first active edge after release starts slot 0, with tick=0.
- Scan:
  - tick counts 0..DIV-1 and wraps to 0.
  - On wrap, idx increments 0..SIZE-1 and wraps to 0.
- Snapshot:
  - Loaded on the edge where tick==DIV-1 and idx==SIZE-1 (frame end): val_s<=value, dp_s<=dp_in, lz_s<=lz_en.
  - Input changes mid-frame are not displayed until the following frame.
  - The first frame after reset displays the reset snapshot, i.e. all zeros with LZ off.
- Outputs are registered. Outputs in cycle n+1 are a function of (tick, idx, snapshot, blank) in cycle n, giving 1-cycle latency.
- Guard interval: tick<GUARD gives an=4'hF, seg=7'h7F, dp=1.
- Active interval: tick≥GUARD gives:
  - an = all ones except bit idx = 0.
  - seg = glyph(val_s nibble idx).
  - dp = ~dp_s[idx].
- an[3:SIZE] are always 1.
- Glyph table, hex {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Leading-zero blanking (lz_s=1):
  - Digit i>0 is blanked when nibbles i..SIZE-1 of val_s are all zero. A blanked digit shows seg=7'h7F; its anode and dp behave normally.
  - Digit 0 is never blanked, so value 0 shows "0".
- blank=1 overrides everything: the next registered outputs are an=4'hF, seg=7'h7F, dp=1. The scan counters and snapshot keep running.
- Reset asserted mid-slot or mid-frame: outputs go dark immediately, asynchronously. After release, scanning restarts from idx=0, tick=0 with a zero snapshot.
- Counter widths:
  - tick: clog2(DIV) bits, compared to DIV-1 exactly, no free-running wrap.
  - idx: 2 bits.

Decomposition:
- Shared package:
  - SEG_OFF=7'h7F and AN_OFF=4'hF.
  - The 16-entry glyph constant table.
  - The tick-width function.
- One sub-module, hex7seg: combinational 4-bit nibble to 7-bit active-low glyph decoder, instantiated once on the selected nibble.

Test Plan (bench uses SIZE=4, DIV=8, GUARD=2):
- Reset and scan:
  - Stimulus: hold rst=0 for 5 cycles, release with value=16'h1234, dp_in=0, lz_en=0.
  - Outputs stay dark through reset.
  - Frame 1 shows "0000" (seg=40 on each digit).
  - Frame 2 slot 0: an=1111 for 2 cycles, then an=1110, seg=19, dp=1 for 6 cycles.
  - Slots 1..3 show seg=30, 24, 79 with an=1101, 1011, 0111.
- No tearing:
  - Stimulus: change value from 16'h1234 to 16'hABCD during the idx=1 slot.
  - Remaining slots still show 1 and 2 (seg 24, 79).
  - The next frame shows D, C, b, A (21, 46, 03, 08).
- Leading-zero blanking:
  - Stimulus: value=16'h0050, lz_en=1.
  - Next frame: digit0 seg=40, digit1 seg=12, digits 2 and 3 seg=7F with their anodes still pulsing.
  - value=0 shows digit0 seg=40 and the others 7F.
- Decimal point:
  - Stimulus: dp_in=4'b0100.
  - dp=0 only during the active interval of idx=2 in the following frame; dp=1 otherwise, including guard cycles.
- Blank and async reset:
  - Stimulus: assert blank for 10 cycles mid-frame.
  - The outputs are dark 1 cycle later, and the scan position continues unchanged.
  - Then pulse rst low between edges: an, seg and dp go off without a clock edge, and scanning restarts at idx=0.
- SIZE=2 variant:
  - Stimulus: value=8'hF7.
  - an[3:2] stay 1. idx alternates 0, 1 every 8 cycles, showing seg 78 then 0E.
